// File: rtl/s32x_sdr_arbiter.sv
// s32x_sdr_arbiter: round-robin N-channel arbiter for the SH-2 SDRAM port.
// Channels raise i_ch_cs and hold it until their o_ch_wait bit drops.
// The FSM runs IDLE -> BUSY -> DONE -> IDLE. It grants one channel at a time
// and drives registered o_sdr_* signals to the SDRAM controller.
// A channel's acknowledge (ack_hold) becomes visible after the DONE
// turnaround cycle, which gives a minimum request-to-release time of 3 cycles.
// Optional feature macro: S32X_SDR_WPOST_EN adds a one-entry posted-write
// buffer per channel. In the default build (macro undefined) writes behave
// exactly like reads.
module s32x_sdr_arbiter #(
    parameter int NCH = 2,
    parameter int AW  = 17,
    parameter int DW  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NCH*AW-1:0]     i_ch_a,
    input  logic [NCH*DW-1:0]     i_ch_do,
    input  logic [NCH-1:0]        i_ch_cs,
    input  logic [NCH*(DW/8)-1:0] i_ch_we,
    input  logic [NCH-1:0]        i_ch_rd,
    output logic [DW-1:0]         o_ch_di,
    output logic [NCH-1:0]        o_ch_wait,
    output logic [AW-1:0]         o_sdr_a,
    output logic [DW-1:0]         o_sdr_do,
    output logic                  o_sdr_cs,
    output logic [DW/8-1:0]       o_sdr_we,
    output logic                  o_sdr_rd,
    input  logic [DW-1:0]         i_sdr_di,
    input  logic                  i_sdr_wait
);

    localparam int BW = DW / 8;
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_g;
    logic            r_g_buf;      // current access drains a posted-write buffer
    logic            r_ack_pend;   // completion seen with CS still high
    logic [NCH-1:0]  r_ack_hold;
    logic [AW-1:0]   r_sdr_a;
    logic [DW-1:0]   r_sdr_do;
    logic [BW-1:0]   r_sdr_we;
    logic            r_sdr_cs;
    logic            r_sdr_rd;
    logic [DW-1:0]   r_ch_di;

    logic [NCH-1:0]  w_req;
    logic [NCH-1:0]  w_ack_set;
    logic [NCH-1:0]  w_ack_next;
    logic [NCH-1:0]  w_src_buf;
    logic [NCH-1:0]  w_src_rd;
    logic [AW-1:0]   w_src_a  [NCH];
    logic [DW-1:0]   w_src_do [NCH];
    logic [BW-1:0]   w_src_we [NCH];
    logic            w_found;
    logic [PW-1:0]   w_pick;
    logic            w_complete;
    logic [PW-1:0]   w_ptr_next;
    logic            w_done_ack;

    assign w_complete = (r_state == ST_BUSY) && !i_sdr_wait;
    assign w_done_ack = (r_state == ST_DONE) && r_ack_pend;
    assign w_ptr_next = (r_g == PW'(NCH - 1)) ? '0 : r_g + 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [AW-1:0] w_a;
            logic [DW-1:0] w_do;
            logic [BW-1:0] w_we;
            logic          w_live;
            logic          w_grant_ack;

            assign w_a    = i_ch_a[gi*AW +: AW];
            assign w_do   = i_ch_do[gi*DW +: DW];
            assign w_we   = i_ch_we[gi*BW +: BW];
            assign w_live = i_ch_cs[gi] & ~r_ack_hold[gi];
            assign w_grant_ack = w_done_ack && (r_g == PW'(gi)) && i_ch_cs[gi];

`ifdef S32X_SDR_WPOST_EN
            logic          r_wb_valid;
            logic [AW-1:0] r_wb_a;
            logic [DW-1:0] r_wb_do;
            logic [BW-1:0] r_wb_we;
            logic          w_is_wr;
            logic          w_cap;
            logic          w_drain;

            assign w_is_wr = |w_we;
            assign w_cap   = w_live & ~r_wb_valid & w_is_wr;
            assign w_drain = w_complete & r_g_buf & (r_g == PW'(gi));

            // Posted-write buffer: capture a write on sampling, retire on drain completion
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_wb_valid <= 1'b0;
                    r_wb_a     <= '0;
                    r_wb_do    <= '0;
                    r_wb_we    <= '0;
                end else if (w_cap) begin
                    r_wb_valid <= 1'b1;
                    r_wb_a     <= w_a;
                    r_wb_do    <= w_do;
                    r_wb_we    <= w_we;
                end else if (w_drain) begin
                    r_wb_valid <= 1'b0;
                end
            end

            // A valid buffer is the channel's only request; live reads wait behind it
            assign w_req[gi]     = r_wb_valid | (w_live & ~w_is_wr);
            assign w_src_buf[gi] = r_wb_valid;
            assign w_src_a[gi]   = r_wb_valid ? r_wb_a  : w_a;
            assign w_src_do[gi]  = r_wb_valid ? r_wb_do : w_do;
            assign w_src_we[gi]  = r_wb_valid ? r_wb_we : w_we;
            assign w_src_rd[gi]  = r_wb_valid ? 1'b0    : i_ch_rd[gi];
            assign w_ack_set[gi] = w_cap | w_grant_ack;
`else
            assign w_req[gi]     = w_live;
            assign w_src_buf[gi] = 1'b0;
            assign w_src_a[gi]   = w_a;
            assign w_src_do[gi]  = w_do;
            assign w_src_we[gi]  = w_we;
            assign w_src_rd[gi]  = i_ch_rd[gi];
            assign w_ack_set[gi] = w_grant_ack;
`endif
            // Hold stays set while CS is high; a sampled-low CS clears it
            assign w_ack_next[gi] = w_ack_set[gi] | (r_ack_hold[gi] & i_ch_cs[gi]);
        end
    endgenerate

    // Round-robin pick: first requesting index at or after r_ptr, wrapping
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = int'(r_ptr) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (w_req[idx]) begin
                w_found = 1'b1;
                w_pick  = PW'(idx);
            end
        end
    end

    // Per-channel acknowledge hold register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ack_hold <= '0;
        end else begin
            r_ack_hold <= w_ack_next;
        end
    end

    // Grant FSM with registered downstream signals and read-data capture
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_g        <= '0;
            r_g_buf    <= 1'b0;
            r_ack_pend <= 1'b0;
            r_sdr_a    <= '0;
            r_sdr_do   <= '0;
            r_sdr_we   <= '0;
            r_sdr_cs   <= 1'b0;
            r_sdr_rd   <= 1'b0;
            r_ch_di    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_g      <= w_pick;
                        r_g_buf  <= w_src_buf[w_pick];
                        r_sdr_a  <= w_src_a[w_pick];
                        r_sdr_do <= w_src_do[w_pick];
                        r_sdr_we <= w_src_we[w_pick];
                        r_sdr_rd <= w_src_rd[w_pick];
                        r_sdr_cs <= 1'b1;
                        r_state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!i_sdr_wait) begin
                        // Only reads update the shared read-data register
                        if (r_sdr_we == '0) begin
                            r_ch_di <= i_sdr_di;
                        end
                        r_ack_pend <= i_ch_cs[r_g] & ~r_g_buf;
                        r_sdr_cs   <= 1'b0;
                        r_sdr_we   <= '0;
                        r_sdr_rd   <= 1'b0;
                        r_ptr      <= w_ptr_next;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_ack_pend <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ch_wait = i_ch_cs & ~r_ack_hold;
    assign o_ch_di   = r_ch_di;
    assign o_sdr_a   = r_sdr_a;
    assign o_sdr_do  = r_sdr_do;
    assign o_sdr_we  = r_sdr_we;
    assign o_sdr_cs  = r_sdr_cs;
    assign o_sdr_rd  = r_sdr_rd;

endmodule
